lcd_timing_gen: RTL and testbench
=================================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have no parameters; all timing values come from the internal ID table (REQ-011).
REQ-002 clk  input  1  pixel clock; the only clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 lcd_id  input  16  panel ID from the upstream ID reader; static once nonzero.
REQ-005 pixel_data  input  24  RGB888 pixel from the pattern source, valid the cycle after pixel_req.
REQ-006 pixel_req  output  1  pixel request to the pattern source.
REQ-007 pixel_xpos / pixel_ypos  output  11 each  coordinates of the requested pixel.
REQ-008 h_disp / v_disp  output  11 each  active width/height of the current panel.
REQ-009 timing_valid  output  1  supported panel loaded; timing running.
REQ-010 lcd_hs, lcd_vs, lcd_de, lcd_rgb[23:0], lcd_bl  output  panel pins; hs/vs active-low.

Function
REQ-011 Timing table, listed as ID: H sync/back/disp/front; V sync/back/disp/front.
- 4342: 41/2/480/2; 10/2/272/2
- 7084: 128/88/800/40; 2/33/480/10
- 7016: 20/140/1024/160; 3/20/600/12
- 4384: 128/88/800/40; 2/33/480/10
- 1018: 10/80/1280/70; 3/10/800/10
- H_TOTAL and V_TOTAL are the sums of each row.
REQ-012 Every other lcd_id value is unsupported.
REQ-013 Two states: IDLE and RUN.
REQ-014 IDLE -> RUN when lcd_id is supported.
- The ID is latched into cur_id.
- h_cnt and v_cnt start at 0 on the next cycle.
REQ-015 RUN never returns to IDLE except via rst.
REQ-016 A change of lcd_id during RUN is applied only at the frame end (h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1).
- New ID supported: it is loaded.
- New ID unsupported: the old cur_id is retained.
REQ-017 h_cnt is 11 bits and counts 0..H_TOTAL-1, then wraps to 0.
REQ-018 v_cnt is 11 bits and increments when h_cnt wraps; it counts 0..V_TOTAL-1, then wraps to 0.
REQ-019 The active window is defined as:
- h_cnt in [HS+HB, HS+HB+HD)
- v_cnt in [VS+VB, VS+VB+VD)
REQ-020 Stage 1 (registered) is evaluated from the counter values of the same cycle:
- pixel_req = active window
- pixel_xpos = h_cnt-(HS+HB) when requesting, else 0
- pixel_ypos = v_cnt-(VS+VB) when requesting, else 0
REQ-021 Stage 2 (registered):
- lcd_de = pixel_req
- lcd_rgb = pixel_req ? pixel_data : 0
REQ-022 Sync outputs are delayed two cycles from their counter condition, so they align with lcd_de:
- lcd_hs is low for h_cnt<HS.
- lcd_vs is low for v_cnt<VS.
REQ-023 Pipeline latency:
- counter -> pixel_req: 1 cycle
- pixel_req -> lcd_de/lcd_rgb: 1 cycle
REQ-024 In IDLE:
- counters are held at 0
- pixel_req=0, lcd_de=0, lcd_rgb=0
- lcd_hs=1, lcd_vs=1
- timing_valid=0, h_disp=v_disp=0
REQ-025 In RUN:
- timing_valid=1
- h_disp/v_disp = HD/VD of cur_id
- lcd_bl=1
REQ-026 lcd_bl=0 in IDLE.

Reset
REQ-027 On rst=1 at a clock edge the block SHALL enter IDLE with all values below, regardless of any frame in progress:
- cur_id=0, h_cnt=0, v_cnt=0
- pixel_req=0, pixel_xpos=0, pixel_ypos=0
- lcd_de=0, lcd_rgb=0, lcd_hs=1, lcd_vs=1, lcd_bl=0
- timing_valid=0, h_disp=0, v_disp=0
REQ-028 After rst deasserts, the block SHALL start RUN no earlier than the first cycle with a supported lcd_id.

Verification
REQ-029 lcd_id=4342 after reset -> the bench SHALL observe:
- timing_valid=1, h_disp=480, v_disp=272
- 525 clocks per line; 286 lines per frame
- lcd_hs low 41 clocks per line
- lcd_de high 480 clocks per active line
REQ-030 lcd_id=7084 -> the bench SHALL observe:
- first pixel_req at h_cnt=216, v_cnt=35, with xpos=0, ypos=0
- lcd_de rises one clock later
- lcd_rgb equals the pixel_data presented in that clock
REQ-031 lcd_id=1018 -> the bench SHALL observe:
- the last pixel_req of a frame has xpos=1279, ypos=799
- h_cnt wraps 1439->0; v_cnt wraps 822->0
REQ-032 lcd_id=0 or 16'h1234 held -> the bench SHALL observe timing_valid=0, lcd_de=0, lcd_hs=lcd_vs=1 and lcd_bl=0 indefinitely.
REQ-033 Change lcd_id 4342->7016 mid-frame -> the bench SHALL observe:
- 4342 timing until the frame end
- then h_disp=1024, v_disp=600, line length 1344
REQ-034 rst pulsed mid active line -> the bench SHALL observe:
- next cycle: all outputs at their reset values
- after rst drops with a supported ID: the frame restarts from h_cnt=v_cnt=0

Source files
------------

// File: rtl/lcd_timing_gen.sv
// RGB LCD timing generator: selects panel timing from the panel ID, runs the
// sync/active counters and a two-stage pixel request / pixel output pipeline.
module lcd_timing_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lcd_id,
  input  logic [23:0] pixel_data,
  output logic        pixel_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        timing_valid,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl
);

  // state | meaning
  // IDLE  | no supported panel yet; counters at 0, panel pins quiet
  // RUN   | timing running for cur_id; left only through rst
  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic        ok;
    logic [10:0] hs, hb, hd, hf;
    logic [10:0] vs, vb, vd, vf;
  } timing_t;

  // Panel IDs are the hex codes reported by the upstream ID reader.
  function automatic timing_t lookup(input logic [15:0] id);
    timing_t t;
    t = '0;
    case (id)
      16'h4342: t = '{1'b1, 11'd41,  11'd2,   11'd480,  11'd2,   11'd10, 11'd2,  11'd272, 11'd2};
      16'h7084: t = '{1'b1, 11'd128, 11'd88,  11'd800,  11'd40,  11'd2,  11'd33, 11'd480, 11'd10};
      16'h7016: t = '{1'b1, 11'd20,  11'd140, 11'd1024, 11'd160, 11'd3,  11'd20, 11'd600, 11'd12};
      16'h4384: t = '{1'b1, 11'd128, 11'd88,  11'd800,  11'd40,  11'd2,  11'd33, 11'd480, 11'd10};
      16'h1018: t = '{1'b1, 11'd10,  11'd80,  11'd1280, 11'd70,  11'd3,  11'd10, 11'd800, 11'd10};
      default:  t = '0;
    endcase
    return t;
  endfunction

  state_t      state;
  logic [15:0] cur_id;
  logic [10:0] h_cnt, v_cnt;
  logic        hs_d1, vs_d1;

  timing_t     cur_t, new_t;
  logic [10:0] h_total, v_total, h_start, h_end, v_start, v_end;
  logic        h_last, v_last, active;

  always_comb begin
    cur_t   = lookup(cur_id);
    new_t   = lookup(lcd_id);
    h_total = cur_t.hs + cur_t.hb + cur_t.hd + cur_t.hf;
    v_total = cur_t.vs + cur_t.vb + cur_t.vd + cur_t.vf;
    h_start = cur_t.hs + cur_t.hb;
    v_start = cur_t.vs + cur_t.vb;
    h_end   = h_start + cur_t.hd;
    v_end   = v_start + cur_t.vd;
    h_last  = (h_cnt == h_total - 11'd1);
    v_last  = (v_cnt == v_total - 11'd1);
    active  = (state == RUN) && (h_cnt >= h_start) && (h_cnt < h_end)
              && (v_cnt >= v_start) && (v_cnt < v_end);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_id       <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      pixel_req    <= 1'b0;
      pixel_xpos   <= '0;
      pixel_ypos   <= '0;
      hs_d1        <= 1'b1;
      vs_d1        <= 1'b1;
      lcd_de       <= 1'b0;
      lcd_rgb      <= '0;
      lcd_hs       <= 1'b1;
      lcd_vs       <= 1'b1;
      lcd_bl       <= 1'b0;
      timing_valid <= 1'b0;
      h_disp       <= '0;
      v_disp       <= '0;
    end else begin
      // Stage 1 from this cycle's counters; stage 2 follows one clock later.
      pixel_req  <= active;
      pixel_xpos <= active ? h_cnt - h_start : '0;
      pixel_ypos <= active ? v_cnt - v_start : '0;
      hs_d1      <= !((state == RUN) && (h_cnt < cur_t.hs));
      vs_d1      <= !((state == RUN) && (v_cnt < cur_t.vs));
      lcd_de     <= pixel_req;
      lcd_rgb    <= pixel_req ? pixel_data : '0;
      lcd_hs     <= hs_d1;
      lcd_vs     <= vs_d1;

      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (new_t.ok) begin
            state        <= RUN;
            cur_id       <= lcd_id;
            timing_valid <= 1'b1;
            lcd_bl       <= 1'b1;
            h_disp       <= new_t.hd;
            v_disp       <= new_t.vd;
          end
        end
        RUN: begin
          if (h_last) begin
            h_cnt <= '0;
            if (v_last) begin
              v_cnt <= '0;
              // ID changes take effect only on a frame boundary; unsupported IDs are ignored.
              if (new_t.ok) begin
                cur_id <= lcd_id;
                h_disp <= new_t.hd;
                v_disp <= new_t.vd;
              end
            end else begin
              v_cnt <= v_cnt + 11'd1;
            end
          end else begin
            h_cnt <= h_cnt + 11'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: frame-position model compared every cycle, plus
// directed measurements of line/frame timing, ID switching and reset.
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lcd_id = 16'h0;
  logic [23:0] pixel_data = 24'h0;
  logic        pixel_req, timing_valid, lcd_hs, lcd_vs, lcd_de, lcd_bl;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic [23:0] lcd_rgb;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_timing_gen dut (
    .clk(clk), .rst(rst), .lcd_id(lcd_id), .pixel_data(pixel_data),
    .pixel_req(pixel_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .h_disp(h_disp), .v_disp(v_disp), .timing_valid(timing_valid),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .lcd_bl(lcd_bl)
  );

  always #5 clk = ~clk;
  always @(negedge clk) pixel_data = 24'($urandom);

  // k: 0..3 = H sync/back/disp/front, 4..7 = V sync/back/disp/front
  function automatic int tv(input logic [15:0] id, input int k);
    int r[8];
    case (id)
      16'h4342: r = '{41, 2, 480, 2, 10, 2, 272, 2};
      16'h7084: r = '{128, 88, 800, 40, 2, 33, 480, 10};
      16'h7016: r = '{20, 140, 1024, 160, 3, 20, 600, 12};
      16'h4384: r = '{128, 88, 800, 40, 2, 33, 480, 10};
      16'h1018: r = '{10, 80, 1280, 70, 3, 10, 800, 10};
      default:  r = '{default: 0};
    endcase
    return r[k];
  endfunction

  function automatic int htot(input logic [15:0] id);
    return tv(id, 0) + tv(id, 1) + tv(id, 2) + tv(id, 3);
  endfunction

  function automatic int vtot(input logic [15:0] id);
    return tv(id, 4) + tv(id, 5) + tv(id, 6) + tv(id, 7);
  endfunction

  // Model: position within the frame as a single linear index.
  bit          m_run = 1'b0;
  logic [15:0] m_id = 16'h0;
  int          m_p = 0;
  int          mht, mh, mv, mhx, mvy;
  logic        e_req, e_tv, e_hs, e_vs, e_de, e_bl, e_hs1, e_vs1;
  logic [10:0] e_x, e_y, e_hd, e_vd;
  logic [23:0] e_rgb;
  logic [73:0] act_v, exp_v;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_id = 16'h0; m_p = 0;
      e_req = 1'b0; e_x = '0; e_y = '0; e_hs1 = 1'b1; e_vs1 = 1'b1;
      e_de = 1'b0; e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1;
      e_tv = 1'b0; e_bl = 1'b0; e_hd = '0; e_vd = '0;
    end else begin
      e_de  = e_req;
      e_rgb = e_req ? pixel_data : '0;
      e_hs  = e_hs1;
      e_vs  = e_vs1;
      if (m_run) begin
        mht = htot(m_id);
        mh  = m_p % mht;
        mv  = m_p / mht;
        mhx = mh - tv(m_id, 0) - tv(m_id, 1);
        mvy = mv - tv(m_id, 4) - tv(m_id, 5);
        e_req = (mhx >= 0) && (mhx < tv(m_id, 2)) && (mvy >= 0) && (mvy < tv(m_id, 6));
        e_x   = e_req ? 11'(mhx) : '0;
        e_y   = e_req ? 11'(mvy) : '0;
        e_hs1 = (mh >= tv(m_id, 0));
        e_vs1 = (mv >= tv(m_id, 4));
        if (m_p == mht * vtot(m_id) - 1) begin
          m_p = 0;
          if (tv(lcd_id, 2) != 0) m_id = lcd_id;
        end else begin
          m_p = m_p + 1;
        end
      end else begin
        e_req = 1'b0; e_x = '0; e_y = '0; e_hs1 = 1'b1; e_vs1 = 1'b1;
        if (tv(lcd_id, 2) != 0) begin
          m_run = 1'b1; m_id = lcd_id; m_p = 0;
        end
      end
      e_tv = m_run;
      e_bl = m_run;
      e_hd = m_run ? 11'(tv(m_id, 2)) : '0;
      e_vd = m_run ? 11'(tv(m_id, 6)) : '0;
    end
    #1;
    act_v = {pixel_req, pixel_xpos, pixel_ypos, h_disp, v_disp, timing_valid,
             lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl};
    exp_v = {e_req, e_x, e_y, e_hd, e_vd, e_tv, e_hs, e_vs, e_de, e_rgb, e_bl};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic out_sel(input int s);
    case (s)
      0: return lcd_hs;
      1: return lcd_vs;
      2: return lcd_de;
      3: return pixel_req;
      default: return timing_valid;
    endcase
  endfunction

  task automatic wait_for(input int s, input logic val, input int budget, output int n);
    n = 0;
    while (out_sel(s) !== val && n < budget) begin
      step;
      n++;
    end
    if (out_sel(s) !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_timeout sel=%0d actual=%b required=%b", s, out_sel(s), val);
      n = -1;
    end
  endtask

  task automatic measure_line(output int low, output int period);
    int n;
    wait_for(0, 1'b1, 3000, n);
    wait_for(0, 1'b0, 3000, n);
    low = 0;
    while (lcd_hs === 1'b0 && low < 3000) begin
      step;
      low++;
    end
    wait_for(0, 1'b0, 3000, n);
    period = low + n;
  endtask

  logic [10:0] force_val;

  // Skip ahead inside the frame by overriding the line counter for one clock.
  task automatic jump_v(input int v, input int hmax, output int h0);
    int ht;
    h0 = -1;
    ht = htot(m_id);
    for (int i = 0; i < 4000 && h0 < 0; i++) begin
      @(negedge clk);
      if (m_p % ht < hmax) h0 = m_p % ht;
    end
    if (h0 < 0) begin
      check("jump_window", h0, 0);
      h0 = 0;
    end else begin
      force_val = 11'(v);
      force dut.v_cnt = force_val;
      m_p = v * ht + h0;
      @(negedge clk);
      release dut.v_cnt;
    end
  endtask

  initial begin
    int low, per, n, c, h0, lx, ly;
    logic seen;
    logic [23:0] d;

    repeat (3) step;
    check("rst_tv", timing_valid, 0);
    check("rst_de", lcd_de, 0);
    check("rst_hs", lcd_hs, 1);
    check("rst_vs", lcd_vs, 1);
    check("rst_bl", lcd_bl, 0);
    check("rst_hdisp", h_disp, 0);

    @(negedge clk); rst = 1'b0; lcd_id = 16'h0;
    repeat (200) step;
    check("id0_tv", timing_valid, 0);
    check("id0_bl", lcd_bl, 0);
    @(negedge clk); lcd_id = 16'h1234;
    repeat (200) step;
    check("id1234_tv", timing_valid, 0);
    check("id1234_hs", lcd_hs, 1);
    check("id1234_vs", lcd_vs, 1);
    check("id1234_de", lcd_de, 0);

    @(negedge clk); lcd_id = 16'h4342;
    step;
    check("4342_tv", timing_valid, 1);
    check("4342_hdisp", h_disp, 480);
    check("4342_vdisp", v_disp, 272);
    check("4342_bl", lcd_bl, 1);
    measure_line(low, per);
    check("4342_hs_low", low, 41);
    check("4342_line_len", per, 525);
    wait_for(2, 1'b1, 8000, n);
    c = 0;
    while (lcd_de === 1'b1 && c < 3000) begin step; c++; end
    check("4342_de_high", c, 480);

    // Mid-frame switch to 7016 waits for the end of the 4342 frame.
    @(negedge clk); lcd_id = 16'h7016;
    repeat (600) step;
    check("switch_hold_hdisp", h_disp, 480);
    jump_v(284, 523, h0);
    c = 1;
    do begin step; c++; end while (h_disp !== 11'd1024 && c < 4000);
    check("switch_at_frame_end", c, (525 - h0) + 525);
    check("7016_vdisp", v_disp, 600);
    measure_line(low, per);
    check("7016_hs_low", low, 20);
    check("7016_line_len", per, 1344);

    // Reset in the middle of an active line.
    jump_v(30, 1342, h0);
    wait_for(2, 1'b1, 3000, n);
    repeat (100) step;
    @(negedge clk); rst = 1'b1; lcd_id = 16'h7084;
    step;
    check("midrst_tv", timing_valid, 0);
    check("midrst_req", pixel_req, 0);
    check("midrst_xpos", pixel_xpos, 0);
    check("midrst_de", lcd_de, 0);
    check("midrst_rgb", lcd_rgb, 0);
    check("midrst_hs", lcd_hs, 1);
    check("midrst_vs", lcd_vs, 1);
    check("midrst_bl", lcd_bl, 0);
    check("midrst_hdisp", h_disp, 0);
    @(negedge clk); rst = 1'b0;
    c = 0;
    do begin step; c++; end while (pixel_req !== 1'b1 && c < 40000);
    check("7084_first_req_delay", c, 1 + 35 * 1056 + 216 + 1);
    check("7084_first_xpos", pixel_xpos, 0);
    check("7084_first_ypos", pixel_ypos, 0);
    check("7084_de_before", lcd_de, 0);
    @(negedge clk); #1 d = pixel_data;
    step;
    check("7084_de_rise", lcd_de, 1);
    check("7084_rgb", lcd_rgb, d);
    check("7084_hdisp", h_disp, 800);

    @(negedge clk); lcd_id = 16'h1018;
    jump_v(523, 1054, h0);
    c = 0;
    while (h_disp !== 11'd1280 && c < 4000) begin step; c++; end
    check("1018_hdisp", h_disp, 1280);
    check("1018_vdisp", v_disp, 800);
    measure_line(low, per);
    check("1018_hs_low", low, 10);
    check("1018_line_len", per, 1440);

    jump_v(812, 80, h0);
    seen = 1'b0; lx = -1; ly = -1; c = 0;
    while (!(seen && pixel_req !== 1'b1) && c < 3000) begin
      step; c++;
      if (pixel_req === 1'b1) begin seen = 1'b1; lx = pixel_xpos; ly = pixel_ypos; end
    end
    check("1018_last_xpos", lx, 1279);
    check("1018_last_ypos", ly, 799);

    jump_v(821, 1438, h0);
    c = 1;
    do begin step; c++; end while (lcd_vs !== 1'b0 && c < 5000);
    check("1018_vwrap_delay", c, (1440 - h0) + 1440 + 2);

    repeat (5) step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
